ibis_texel_fetch: RTL
=====================

Name: ibis_texel_fetch

Overview:
- Consumer end of the texture mapper's address interface.
- Accepts one tile map address and stencil result per mapper beat, then issues a read to synchronous tile/texel RAM for stencil-passing beats.
- Substitutes a transparent index for stencil-failing beats.
- Delivers texels in strict acceptance order through a small output FIFO with valid/ready handshake, and returns backpressure to the mapper.

Parameters:
- TILE_SIZE_POW2, 5, log2 of tile edge; address width is 2*TILE_SIZE_POW2.
- TEXEL_WIDTH, 8, width of a texel (palette index).
- MEM_LATENCY, 2, read latency of texel RAM in cycles; legal range 1..4.
- FIFO_DEPTH_POW2, 2, log2 of output FIFO depth; depth must be >= MEM_LATENCY+1.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous reset, active-high.
- map_valid  in  1  mapper beat present (mapper ready qualified by its enable).
- map_address  in  2*TILE_SIZE_POW2  {y, x} tile texel address.
- stencil_test  in  1  1 = texel inside tile, fetch; 0 = outside, substitute.
- transparent_index  in  TEXEL_WIDTH  value used for stencil-fail beats; sampled at accept.
- map_stall  out  1  1 = cannot accept; mapper must hold its enable low.
- mem_rd_en  out  1  texel RAM read strobe.
- mem_rd_addr  out  2*TILE_SIZE_POW2  texel RAM read address.
- mem_rd_data  in  TEXEL_WIDTH  RAM data, valid MEM_LATENCY cycles after mem_rd_en.
- texel_valid  out  1  output FIFO non-empty.
- texel_ready  in  1  downstream consumes head when high with texel_valid.
- texel_data  out  TEXEL_WIDTH  head texel.
- texel_stencil  out  1  stencil_test of head beat.
- overflow  out  1  sticky error flag.

Behaviour:
- Reset (areset=1 at a clock edge) forces the following state:
  - texel_valid=0, texel_data=0, texel_stencil=0, map_stall=0, overflow=0, mem_rd_en=0.
  - Delay line cleared; FIFO emptied.
  - Accept is suppressed while areset=1.
- Accept = map_valid & ~map_stall & ~areset.
- mem_rd_en = accept & stencil_test (combinational); mem_rd_addr = map_address, passed through.
- A stencil-fail beat never strobes the RAM.
- Delay line: MEM_LATENCY stages, each holding {valid, stencil, transparent_index}. Stage 0 captures on accept; it shifts every cycle with no stall.
- At the last stage, if valid, the FIFO is written with:
  - data = stencil ? mem_rd_data : held transparent_index;
  - texel_stencil = stencil.
- Latency: accept in cycle N, RAM data in cycle N+MEM_LATENCY, texel_valid=1 in cycle N+MEM_LATENCY+1 (FIFO empty case).
- Ordering is strict FIFO; pass and fail beats never reorder.
- FIFO is first-word fall-through: texel_data and texel_stencil reflect the head whenever texel_valid=1. A pop occurs on texel_valid & texel_ready.
- Credit rule: map_stall = (fifo_count + number of valid delay-line stages) >= 2^FIFO_DEPTH_POW2.
  - Computed from registered state only; no combinational path from texel_ready or map_valid.
  - A FIFO write can therefore never find the FIFO full.
- Push and pop in the same cycle: count unchanged, head advances.
- Pop when empty: no effect.
- Full throughput: with texel_ready=1 and depth >= MEM_LATENCY+1, one beat per cycle sustained and map_stall never asserts.
- map_valid=1 while map_stall=1:
  - beat dropped, no RAM read;
  - overflow set to 1 and held until reset.
- Reset mid-operation: all in-flight beats are discarded. RAM data returning after reset is ignored (delay line is empty).
- Pointer wrap: FIFO read/write pointers are FIFO_DEPTH_POW2 bits and wrap modulo depth; count is FIFO_DEPTH_POW2+1 bits.

Test Plan:
1. Reset, texel_ready=1, one beat: address 0x3A5, stencil 1; RAM model returns address[7:0].
   -> mem_rd_en=1 with mem_rd_addr=0x3A5 in the accept cycle.
   -> texel_valid=1 exactly 3 cycles later with texel_data=0xA5, texel_stencil=1.
2. Beats pass 0x001, fail (transparent_index 0xFF), pass 0x002, back to back.
   -> mem_rd_en pulses only for the two pass beats.
   -> Output order 0x01, 0xFF, 0x02 with texel_stencil 1, 0, 1.
3. texel_ready=0, continuous map_valid.
   -> Exactly 4 accepts, then map_stall=1.
   -> Raise texel_ready for one cycle: one pop, map_stall=0 the next cycle, a 5th accept follows.
4. While map_stall=1, hold map_valid=1 with address 0x0FF.
   -> overflow=1 and stays 1.
   -> 0x0FF never read, FIFO contents unchanged.
   -> overflow clears only on areset.
5. Two pass beats accepted, areset pulsed for one cycle before their data returns.
   -> No texel_valid afterward; map_stall=0, overflow=0.
6. texel_ready=1, 16 consecutive pass beats at addresses 0..15.
   -> map_stall stays 0.
   -> 16 texels emerge in order 0..15 on consecutive cycles starting 3 cycles after the first accept.

Source files
------------

// File: rtl/ibis_texel_fetch.sv
// Purpose : texel fetch stage; reads stencil-passing mapper beats from tile RAM and substitutes a transparent index for failing ones.
// Latency : accept in cycle N, texel_valid in cycle N+MEM_LATENCY+1 when the output FIFO is empty.
// Backpr. : map_stall is a registered-state credit (FIFO count + in-flight beats vs depth); texel_ready never reaches map_stall combinationally.
//
// Ports:
//   aclk, areset            clock, synchronous active-high reset
//   map_valid/map_address/  mapper beat: {y,x} address, stencil result and
//   stencil_test/           substitute index, all sampled on accept
//   transparent_index
//   map_stall               1 = beat would be dropped (sets overflow)
//   mem_rd_en/mem_rd_addr/  synchronous texel RAM read port, data returns
//   mem_rd_data             MEM_LATENCY cycles after the strobe
//   texel_valid/ready/      first-word fall-through output FIFO head
//   texel_data/stencil
//   overflow                sticky: a beat arrived while stalled
module ibis_texel_fetch #(
  parameter int TILE_SIZE_POW2  = 5,
  parameter int TEXEL_WIDTH     = 8,
  parameter int MEM_LATENCY     = 2,
  parameter int FIFO_DEPTH_POW2 = 2
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        map_valid,
  input  logic [2*TILE_SIZE_POW2-1:0] map_address,
  input  logic                        stencil_test,
  input  logic [TEXEL_WIDTH-1:0]      transparent_index,
  output logic                        map_stall,
  output logic                        mem_rd_en,
  output logic [2*TILE_SIZE_POW2-1:0] mem_rd_addr,
  input  logic [TEXEL_WIDTH-1:0]      mem_rd_data,
  output logic                        texel_valid,
  input  logic                        texel_ready,
  output logic [TEXEL_WIDTH-1:0]      texel_data,
  output logic                        texel_stencil,
  output logic                        overflow
);

  localparam int DEPTH = 1 << FIFO_DEPTH_POW2;
  localparam int CW    = FIFO_DEPTH_POW2 + 1;
  localparam int OW    = FIFO_DEPTH_POW2 + 3;

  // Delay line matching the RAM read latency
  logic [MEM_LATENCY-1:0] dl_vld_q, dl_vld_d;
  logic [MEM_LATENCY-1:0] dl_stn_q, dl_stn_d;
  logic [TEXEL_WIDTH-1:0] dl_idx_q [MEM_LATENCY];

  // Output FIFO
  logic [TEXEL_WIDTH-1:0]     fifo_dat_q [DEPTH];
  logic                       fifo_stn_q [DEPTH];
  logic [FIFO_DEPTH_POW2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_POW2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       overflow_q, overflow_d;

  logic                   accept;
  logic                   fifo_wr;
  logic                   fifo_rd;
  logic [TEXEL_WIDTH-1:0] fifo_wr_dat;
  logic [OW-1:0]          occ;

  // Every accepted beat is either in the delay line or in the FIFO, so this
  // sum is the total number of FIFO slots already promised.
  always_comb begin
    occ = OW'(cnt_q);
    for (int i = 0; i < MEM_LATENCY; i++) begin
      occ = occ + OW'(dl_vld_q[i]);
    end
  end

  assign map_stall   = (occ >= OW'(DEPTH));
  assign accept      = map_valid & ~map_stall & ~areset;
  assign mem_rd_en   = accept & stencil_test;
  assign mem_rd_addr = map_address;

  assign fifo_wr     = dl_vld_q[MEM_LATENCY-1];
  assign fifo_wr_dat = dl_stn_q[MEM_LATENCY-1] ? mem_rd_data : dl_idx_q[MEM_LATENCY-1];

  assign texel_valid   = (cnt_q != '0);
  assign fifo_rd       = texel_valid & texel_ready;
  assign texel_data    = texel_valid ? fifo_dat_q[rd_ptr_q] : '0;
  assign texel_stencil = texel_valid & fifo_stn_q[rd_ptr_q];
  assign overflow      = overflow_q;

  always_comb begin
    dl_vld_d    = '0;
    dl_stn_d    = '0;
    dl_vld_d[0] = accept;
    dl_stn_d[0] = stencil_test;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      dl_vld_d[i] = dl_vld_q[i-1];
      dl_stn_d[i] = dl_stn_q[i-1];
    end
    wr_ptr_d   = fifo_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = fifo_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d      = cnt_q + CW'(fifo_wr) - CW'(fifo_rd);
    overflow_d = overflow_q | (map_valid & map_stall);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      dl_vld_q   <= '0;
      dl_stn_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      dl_vld_q   <= dl_vld_d;
      dl_stn_q   <= dl_stn_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload storage needs no reset: it is qualified by the valid bits and count.
  always_ff @(posedge aclk) begin
    dl_idx_q[0] <= transparent_index;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      dl_idx_q[i] <= dl_idx_q[i-1];
    end
    if (fifo_wr) begin
      fifo_dat_q[wr_ptr_q] <= fifo_wr_dat;
      fifo_stn_q[wr_ptr_q] <= dl_stn_q[MEM_LATENCY-1];
    end
  end

endmodule
